// File: rtl/wb_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and helpers for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / OWNED)
//   SEL_W       : byte-select width for the default 32-bit data path
//   rr_pick()   : behavioural round-robin pick, returns a one-hot grant
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int MAX_M  = 8;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int SEL_W  = DEF_DW / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Scan masters starting at (last+1) mod num_m and grant the first requester.
    // Handy as a golden reference when unit-testing the hardware picker.
    function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                                 input logic [2:0]       last,
                                                 input int unsigned      num_m);
        logic [MAX_M-1:0] gnt;
        int unsigned      idx;
        gnt = '0;
        for (int unsigned i = 1; i <= num_m; i++) begin
            idx = (32'(last) + i) % num_m;
            if ((gnt == '0) && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bundles the master-side and slave-side Wishbone B4 classic signals of the
// arbiter. Signal names carry the arbiter's own direction suffix (_i / _o).
//   m_cyc_i/m_stb_i/m_we_i : per-master strobes            (NUM_M)
//   m_adr_i/m_dat_i/m_sel_i: packed per-master address/data/select
//   m_ack_o/m_err_o        : per-master termination        (NUM_M)
//   m_dat_o                : read data broadcast to all masters
//   s_*_o                  : strobes/address/data towards the shared slave
//   s_ack_i/s_err_i/s_dat_i: slave termination and read data
// Modports:
//   slave  : the arbiter's view (it is the slave of all requesting masters)
//   master : the environment's view (masters plus the shared slave model)
// -----------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    import wb_arb_pkg::*;

    localparam int SW = DW / 8;

    logic [NUM_M-1:0]    m_cyc_i;
    logic [NUM_M-1:0]    m_stb_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M*AW-1:0] m_adr_i;
    logic [NUM_M*DW-1:0] m_dat_i;
    logic [NUM_M*SW-1:0] m_sel_i;
    logic [NUM_M-1:0]    m_ack_o;
    logic [NUM_M-1:0]    m_err_o;
    logic [DW-1:0]       m_dat_o;

    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [SW-1:0]       s_sel_o;
    logic                s_ack_i;
    logic                s_err_i;
    logic [DW-1:0]       s_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_err_i, s_dat_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_err_i, s_dat_i
    );

endinterface

// File: rtl/wb_rr_arbiter_priority.sv
// -----------------------------------------------------------------------------
// wb_rr_priority
// Combinational round-robin picker: rotate the request vector so that
// (last+1) mod NUM_M lands at bit 0, isolate the lowest set bit, rotate back.
// Ports:
//   i_req  : request vector (one bit per master)
//   i_last : index of the previous owner
//   o_gnt  : one-hot grant, all-zero when nothing requests
// -----------------------------------------------------------------------------
module wb_rr_priority
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    localparam int LW   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [LW-1:0]    i_last,
    output logic [NUM_M-1:0] o_gnt
);

    localparam logic [LW-1:0]    LAST_IDX = LW'(NUM_M - 1);
    localparam logic [NUM_M-1:0] ONE      = {{(NUM_M-1){1'b0}}, 1'b1};

    logic [LW-1:0]    w_start;
    logic [NUM_M-1:0] w_rot;
    logic [NUM_M-1:0] w_ffs;

    assign w_start = (i_last >= LAST_IDX) ? '0 : i_last + 1'b1;

    // Rotation amount is a runtime value; enumerating every amount keeps all
    // bit selects constant.
    always_comb begin
        w_rot = '0;
        for (int s = 0; s < NUM_M; s++) begin
            if (w_start == LW'(s)) begin
                for (int i = 0; i < NUM_M; i++) begin
                    w_rot[i] = i_req[(i + s) % NUM_M];
                end
            end
        end
    end

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign w_ffs = w_rot & (~w_rot + ONE);

    always_comb begin
        o_gnt = '0;
        for (int s = 0; s < NUM_M; s++) begin
            if (w_start == LW'(s)) begin
                for (int i = 0; i < NUM_M; i++) begin
                    o_gnt[(i + s) % NUM_M] = w_ffs[i];
                end
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin Wishbone B4 classic arbiter: NUM_M masters share one slave.
// A grant is held for the whole bus cycle (owner CYC high), so multi-beat and
// locked sequences stay atomic. A new owner always costs one idle cycle.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : wb_rr_arbiter_if.slave (master request side + slave side)
//   grant_o  : one-hot current owner (registered)
//   busy_o   : bus owned and owner CYC still high
//
// Build option:
//   WB_ARB_TIMEOUT_EN : adds a watchdog that answers a stalled strobe with a
//                       one-cycle ERR after TIMEOUT cycles without ACK/ERR.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, slave signals quiet, arbitrating among CYC requests
// OWNED | one master granted, its signals muxed through to the slave
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    wb_rr_arbiter_if.slave   bus,
    output logic [NUM_M-1:0] grant_o,
    output logic             busy_o
);

    localparam int            LW       = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int            SW       = DW / 8;
    localparam logic [LW-1:0] LAST_RST = LW'(NUM_M - 1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [NUM_M-1:0] r_grant;
    logic [NUM_M-1:0] w_next_grant;
    logic [LW-1:0]    r_last;
    logic [LW-1:0]    w_next_last;
    logic [NUM_M-1:0] w_pick;

    logic [LW-1:0]    w_owner_idx;
    logic             w_owner_cyc;
    logic             w_owner_stb;
    logic             w_owner_we;
    logic [AW-1:0]    w_owner_adr;
    logic [DW-1:0]    w_owner_dat;
    logic [SW-1:0]    w_owner_sel;
    logic             w_to_hit;

    wb_rr_priority #(
        .NUM_M (NUM_M)
    ) u_priority (
        .i_req  (bus.m_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // r_grant is all-zero outside OWNED, so an AND-OR mux on it already
    // yields zeros on the slave side whenever nobody owns the bus.
    always_comb begin
        w_owner_idx = '0;
        w_owner_cyc = 1'b0;
        w_owner_stb = 1'b0;
        w_owner_we  = 1'b0;
        w_owner_adr = '0;
        w_owner_dat = '0;
        w_owner_sel = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (r_grant[k]) begin
                w_owner_idx = LW'(k);
                w_owner_cyc = bus.m_cyc_i[k];
                w_owner_stb = bus.m_stb_i[k];
                w_owner_we  = bus.m_we_i[k];
                w_owner_adr = bus.m_adr_i[k*AW +: AW];
                w_owner_dat = bus.m_dat_i[k*DW +: DW];
                w_owner_sel = bus.m_sel_i[k*SW +: SW];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_last  <= w_next_last;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last;
        case (r_state)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    w_next_state = OWNED;
                    w_next_grant = w_pick;
                end
            end
            OWNED: begin
                // Returning through IDLE (rather than re-granting here) is
                // what gives the one idle cycle between owners.
                if (!w_owner_cyc) begin
                    w_next_state = IDLE;
                    w_next_grant = '0;
                    w_next_last  = w_owner_idx;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.s_cyc_o = w_owner_cyc;
        bus.s_stb_o = w_owner_cyc & w_owner_stb & ~w_to_hit;
        bus.s_we_o  = w_owner_we;
        bus.s_adr_o = w_owner_adr;
        bus.s_dat_o = w_owner_dat;
        bus.s_sel_o = w_owner_sel;
        bus.m_ack_o = r_grant & {NUM_M{bus.s_ack_i}};
        bus.m_err_o = r_grant & {NUM_M{bus.s_err_i | w_to_hit}};
        bus.m_dat_o = bus.s_dat_i;
        grant_o     = r_grant;
        busy_o      = (r_state == OWNED) & w_owner_cyc;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_to_cnt;
    logic          w_stall;

    // Uses the unmasked strobe so the terminal cycle itself still counts as
    // stalled; the hit then masks s_stb_o for that one cycle.
    assign w_stall  = w_owner_cyc & w_owner_stb & ~bus.s_ack_i & ~bus.s_err_i;
    assign w_to_hit = w_stall & (r_to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (!w_owner_cyc || bus.s_ack_i || bus.s_err_i || w_to_hit) begin
            r_to_cnt <= '0;
        end else if (w_owner_stb) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    // Without the watchdog a hung slave stalls the bus; TIMEOUT has no effect.
    localparam logic TO_NEVER = (TIMEOUT < 0);
    assign w_to_hit = TO_NEVER;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int NUM_M   = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NUM_M-1:0] grant_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int               m_last;
    logic [NUM_M-1:0] m_pending;
    logic [AW-1:0]    m_adr [NUM_M];
    logic [DW-1:0]    m_wdat[NUM_M];
    logic             m_we  [NUM_M];

    wb_rr_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus();

    wb_rr_arbiter #(
        .NUM_M   (NUM_M),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at (last+1), (last+2), ... mod NUM_M.
    function automatic int model_pick(input logic [NUM_M-1:0] req, input int last);
        for (int i = 1; i <= NUM_M; i++) begin
            if (req[(last + i) % NUM_M]) return (last + i) % NUM_M;
        end
        return -1;
    endfunction

    function automatic logic [NUM_M-1:0] onehot(input int k);
        logic [NUM_M-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.m_cyc_i[k]         = 1'b1;
        bus.m_stb_i[k]         = 1'b1;
        bus.m_we_i[k]          = we;
        bus.m_adr_i[k*AW +: AW] = a;
        bus.m_dat_i[k*DW +: DW] = d;
        bus.m_sel_i[k*SW +: SW] = s;
    endtask

    task automatic clr_m(input int k);
        bus.m_cyc_i[k] = 1'b0;
        bus.m_stb_i[k] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_last = NUM_M - 1;
    endtask

    initial begin
        logic [NUM_M-1:0] prev_g;
        int               exp_i;
        int               nb;
        int               wt;
        logic             err;
        logic [DW-1:0]    rd;

        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_dat_i = '0;
        m_last = NUM_M - 1;
        m_pending = '0;

        // ---------------- reset values
        #12;
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_scyc", bus.s_cyc_o, 0);
        chk("rst_sstb", bus.s_stb_o, 0);
        chk("rst_mack", bus.m_ack_o, 0);
        chk("rst_merr", bus.m_err_o, 0);
        tick();
        reset_n = 1'b1;

        // ---------------- single master 0 write, ACK two cycles after STB
        set_m(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("t1_idle_grant", grant_o, 0);
        chk("t1_idle_scyc", bus.s_cyc_o, 0);
        tick(); @(negedge clk);
        chk("t1_grant", grant_o, 2'b01);
        chk("t1_sadr", bus.s_adr_o, 32'h10);
        chk("t1_sdat", bus.s_dat_o, 32'hDEAD_BEEF);
        chk("t1_ssel", bus.s_sel_o, 4'hF);
        chk("t1_swe", bus.s_we_o, 1);
        chk("t1_sstb", bus.s_stb_o, 1);
        chk("t1_busy", busy_o, 1);
        tick(); @(negedge clk);
        chk("t1_noack", bus.m_ack_o, 0);
        tick(); bus.s_ack_i = 1'b1; @(negedge clk);
        chk("t1_ack", bus.m_ack_o, 2'b01);
        tick(); bus.s_ack_i = 1'b0; clr_m(0); @(negedge clk);
        chk("t1_drop_busy", busy_o, 0);
        chk("t1_drop_scyc", bus.s_cyc_o, 0);
        tick(); @(negedge clk);
        chk("t1_idle2_grant", grant_o, 0);
        chk("t1_idle2_sadr", bus.s_adr_o, 0);

        // ---------------- two masters raise CYC together after reset
        do_reset();
        set_m(0, 1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF);
        set_m(1, 1'b0, 32'h0000_0200, 32'h2222_2222, 4'h3);
        tick(); @(negedge clk);
        chk("t2_first", grant_o, 2'b01);
        chk("t2_ack0", bus.m_ack_o, 0);
        tick(); bus.s_ack_i = 1'b1; @(negedge clk);
        chk("t2_ack_owner_only", bus.m_ack_o, 2'b01);
        tick(); bus.s_ack_i = 1'b0; clr_m(0); @(negedge clk);
        chk("t2_drop_scyc", bus.s_cyc_o, 0);
        tick(); @(negedge clk);
        chk("t2_idle_gap", grant_o, 0);
        tick(); @(negedge clk);
        chk("t2_second", grant_o, 2'b10);
        chk("t2_sadr1", bus.s_adr_o, 32'h200);
        chk("t2_ssel1", bus.s_sel_o, 4'h3);
        tick(); bus.s_ack_i = 1'b1; @(negedge clk);
        chk("t2_ack1", bus.m_ack_o, 2'b10);
        tick(); bus.s_ack_i = 1'b0; clr_m(1);
        tick();

        // ---------------- continuous requests: grants rotate 0,1,0,1,0,1
        prev_g = '0;
        for (int i = 0; i < 6; i++) begin
            set_m(0, 1'b1, 32'h0000_1000, 32'hA0A0_0000 + 32'(i), 4'hF);
            set_m(1, 1'b1, 32'h0000_2000, 32'hB0B0_0000 + 32'(i), 4'hF);
            exp_i = i % NUM_M;
            tick(); @(negedge clk);
            chk("t3_rotate", grant_o, onehot(exp_i));
            chk("t3_not_repeat", (grant_o == prev_g), 0);
            prev_g = onehot(exp_i);
            tick(); bus.s_ack_i = 1'b1; @(negedge clk);
            chk("t3_ack", bus.m_ack_o, onehot(exp_i));
            tick(); bus.s_ack_i = 1'b0; clr_m(exp_i);
            tick();
        end
        clr_m(0); clr_m(1);
        tick();

        // ---------------- master 1 four-beat read while master 0 waits
        set_m(1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
        tick(); @(negedge clk);
        chk("t4_grant", grant_o, 2'b10);
        chk("t4_swe", bus.s_we_o, 0);
        for (int b = 1; b <= 4; b++) begin
            tick();
            set_m(0, 1'b1, 32'h0000_4000, 32'h4444_4444, 4'hF);
            bus.s_ack_i = 1'b1;
            bus.s_dat_i = 32'(b);
            @(negedge clk);
            chk("t4_ack", bus.m_ack_o, 2'b10);
            chk("t4_rdat", bus.m_dat_o, 32'(b));
            chk("t4_hold", grant_o, 2'b10);
            tick(); bus.s_ack_i = 1'b0; @(negedge clk);
            chk("t4_hold_gap", grant_o, 2'b10);
        end
        tick(); clr_m(1); @(negedge clk);
        chk("t4_drop_scyc", bus.s_cyc_o, 0);
        tick(); @(negedge clk);
        chk("t4_idle", grant_o, 0);
        tick(); @(negedge clk);
        chk("t4_next_owner", grant_o, 2'b01);

        // ---------------- asynchronous reset mid-beat while master 0 owns
        tick(); bus.s_ack_i = 1'b1; @(negedge clk);
        chk("t5_pre_ack", bus.m_ack_o, 2'b01);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_async_grant", grant_o, 0);
        chk("t5_async_scyc", bus.s_cyc_o, 0);
        chk("t5_async_mack", bus.m_ack_o, 0);
        chk("t5_async_busy", busy_o, 0);
        bus.s_ack_i = 1'b0;
        tick();
        reset_n = 1'b1;
        m_last = NUM_M - 1;
        set_m(1, 1'b1, 32'h0000_5000, 32'h5555_5555, 4'hF);
        tick(); @(negedge clk);
        chk("t5_after_rst", grant_o, 2'b01);
        tick(); clr_m(0); clr_m(1);
        tick(); tick();

        // ---------------- randomized traffic against the reference model
        do_reset();
        m_pending = '0;
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (!m_pending[k] && ($urandom_range(0, 1) == 1)) begin
                    m_pending[k] = 1'b1;
                    m_adr[k]  = $urandom;
                    m_wdat[k] = $urandom;
                    m_we[k]   = 1'($urandom_range(0, 1));
                    set_m(k, m_we[k], m_adr[k], m_wdat[k], 4'hF);
                end
            end
            if (m_pending == '0) begin
                exp_i = $urandom_range(0, NUM_M - 1);
                m_pending[exp_i] = 1'b1;
                m_adr[exp_i]  = $urandom;
                m_wdat[exp_i] = $urandom;
                m_we[exp_i]   = 1'($urandom_range(0, 1));
                set_m(exp_i, m_we[exp_i], m_adr[exp_i], m_wdat[exp_i], 4'hF);
            end
            exp_i = model_pick(m_pending, m_last);
            tick(); @(negedge clk);
            chk("rnd_grant", grant_o, onehot(exp_i));
            chk("rnd_sadr", bus.s_adr_o, m_adr[exp_i]);
            chk("rnd_sdat", bus.s_dat_o, m_wdat[exp_i]);
            chk("rnd_swe", bus.s_we_o, m_we[exp_i]);
            chk("rnd_busy", busy_o, 1);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                wt = $urandom_range(0, 2);
                for (int j = 0; j < wt; j++) begin
                    tick(); bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; @(negedge clk);
                    chk("rnd_wait_ack", bus.m_ack_o, 0);
                end
                tick();
                rd  = $urandom;
                err = ($urandom_range(0, 4) == 0);
                bus.s_ack_i = ~err;
                bus.s_err_i = err;
                bus.s_dat_i = rd;
                @(negedge clk);
                chk("rnd_ack", bus.m_ack_o, err ? '0 : onehot(exp_i));
                chk("rnd_err", bus.m_err_o, err ? onehot(exp_i) : '0);
                chk("rnd_rdat", bus.m_dat_o, rd);
            end
            tick();
            bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
            clr_m(exp_i);
            m_pending[exp_i] = 1'b0;
            m_last = exp_i;
            @(negedge clk);
            chk("rnd_drop_scyc", bus.s_cyc_o, 0);
            tick();
        end
        clr_m(0); clr_m(1);
        tick(); tick();

        // ---------------- slave never answers
        do_reset();
        set_m(0, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == TIMEOUT) begin
                chk("to_err_pulse", bus.m_err_o, 2'b01);
                chk("to_stb_masked", bus.s_stb_o, 0);
            end else begin
                chk("to_no_err", bus.m_err_o, 0);
                chk("to_stb", bus.s_stb_o, 1);
            end
            tick();
        end
        chk("to_grant_kept", grant_o, 2'b01);
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            chk("hang_no_err", bus.m_err_o, 0);
            tick();
        end
        chk("hang_stb", bus.s_stb_o, 1);
        chk("hang_grant", grant_o, 2'b01);
`endif
        clr_m(0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
